// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Optional feature macro used by the top: TRAP_VECTORED_EN.
package core_package;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DRAIN    = 2'd1,
      ST_COMMIT   = 2'd2,
      ST_REDIRECT = 2'd3
   } trap_state_e;

   // Kind of event currently being sequenced
   typedef enum logic [1:0] {
      KIND_EXC  = 2'd0,
      KIND_IRQ  = 2'd1,
      KIND_MRET = 2'd2
   } trap_kind_e;

   // mip/mie bit positions of the machine interrupts
   localparam int MEIP_IDX = 11;
   localparam int MSIP_IDX = 3;
   localparam int MTIP_IDX = 7;

   // mcause codes of the machine interrupts
   localparam logic [4:0] IRQ_CODE_MEI = 5'd11;
   localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
   localparam logic [4:0] IRQ_CODE_MTI = 5'd7;

   // Only MEI, MSI and MTI are considered when deciding whether an interrupt is pending
   localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

   // Return addresses are halfword aligned: bit 0 is always dropped
   function automatic logic [31:0] clear_lsb(input logic [31:0] addr);
      return {addr[31:1], 1'b0};
   endfunction

endpackage

// File: rtl/trap_controller_irq_priority_enc.sv
// Fixed-priority encoder for machine interrupts: MEI > MSI > MTI.
// Input is the already-masked pending vector (mie & mip & 0x888).
module irq_priority_enc
   import core_package::*;
(
   input  logic [31:0] pend_i,
   output logic        valid_o,
   output logic [4:0]  code_o
);

   // Bits outside the three machine interrupts never influence the result
   logic unused_pend;
   assign unused_pend = ^{pend_i[31:12], pend_i[10:8], pend_i[6:4], pend_i[2:0]};

   // Pick the highest-priority pending interrupt
   always_comb begin
      valid_o = 1'b1;
      code_o  = IRQ_CODE_MEI;
      if (pend_i[MEIP_IDX]) begin
         code_o = IRQ_CODE_MEI;
      end else if (pend_i[MSIP_IDX]) begin
         code_o = IRQ_CODE_MSI;
      end else if (pend_i[MTIP_IDX]) begin
         code_o = IRQ_CODE_MTI;
      end else begin
         valid_o = 1'b0;
         code_o  = 5'd0;
      end
   end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates exceptions, MRET and interrupts,
// drains the pipeline, strobes the CSR file once, then redirects fetch.
// Define TRAP_VECTORED_EN to vector interrupts when mtvec mode is 1;
// without it every trap goes to the mtvec base and trap_mode_i is ignored.
// Handshake: redirect_valid_o rises with a stable redirect_pc_o and both hold
// until a clock edge where redirect_ready_i is high; that edge completes the transfer.
module trap_controller
   import core_package::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_valid_i,
   input  logic [4:0]  exc_code_i,
   input  logic [31:0] exc_pc_i,
   input  logic [31:0] exc_tval_i,
   input  logic        mret_i,
   input  logic        irq_pc_valid_i,
   input  logic [31:0] irq_pc_i,
   input  logic [31:0] mie_i,
   input  logic [31:0] mip_i,
   input  logic        global_m_interrupt_en_i,
   input  logic [31:0] trap_base_addr_i,
   input  logic [1:0]  trap_mode_i,
   input  logic [31:0] mepc_i,
   input  logic        drain_done_i,
   input  logic        redirect_ready_i,
   output logic        stall_o,
   output logic        flush_o,
   output logic        trap_commit_o,
   output logic        mret_commit_o,
   output logic [31:0] trap_pc_o,
   output logic [31:0] trap_cause_o,
   output logic [31:0] trap_val_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   output logic [1:0]  dbg_state_o
);

   trap_state_e state_q;
   trap_kind_e  kind_q;
   logic        stall_q;
   logic        flush_q;
   logic        trap_commit_q;
   logic        mret_commit_q;
   logic [31:0] trap_pc_q;
   logic [31:0] trap_cause_q;
   logic [31:0] trap_val_q;
   logic [31:0] mret_target_q;
   logic        redirect_valid_q;
   logic [31:0] redirect_pc_q;

   logic [31:0] irq_pend;
   logic        irq_valid;
   logic [4:0]  irq_code;
   logic        irq_take;
   logic [31:0] target_d;

   assign irq_pend = mie_i & mip_i & IRQ_MASK;

   irq_priority_enc u_irq_enc (
      .pend_i  (irq_pend),
      .valid_o (irq_valid),
      .code_o  (irq_code)
   );

   assign irq_take = global_m_interrupt_en_i & irq_pc_valid_i & irq_valid;

`ifdef TRAP_VECTORED_EN
   // Redirect target: MRET returns to mepc, vectored interrupts offset by cause
   always_comb begin
      target_d = trap_base_addr_i;
      if (kind_q == KIND_MRET) begin
         target_d = mret_target_q;
      end else if ((kind_q == KIND_IRQ) && (trap_mode_i == 2'd1)) begin
         target_d = trap_base_addr_i + {25'd0, trap_cause_q[4:0], 2'b00};
      end
   end
`else
   // mtvec mode has no effect in this build
   logic unused_mode;
   assign unused_mode = ^trap_mode_i;

   // Redirect target: MRET returns to mepc, every trap goes to the base
   always_comb begin
      target_d = trap_base_addr_i;
      if (kind_q == KIND_MRET) begin
         target_d = mret_target_q;
      end
   end
`endif

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= ST_IDLE;
         kind_q           <= KIND_EXC;
         stall_q          <= 1'b0;
         flush_q          <= 1'b0;
         trap_commit_q    <= 1'b0;
         mret_commit_q    <= 1'b0;
         trap_pc_q        <= 32'd0;
         trap_cause_q     <= 32'd0;
         trap_val_q       <= 32'd0;
         mret_target_q    <= 32'd0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= RESET_PC;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (exc_valid_i) begin
                  kind_q       <= KIND_EXC;
                  trap_cause_q <= {27'd0, exc_code_i};
                  trap_pc_q    <= clear_lsb(exc_pc_i);
                  trap_val_q   <= exc_tval_i;
                  state_q      <= ST_DRAIN;
                  stall_q      <= 1'b1;
                  flush_q      <= 1'b1;
               end else if (mret_i) begin
                  kind_q        <= KIND_MRET;
                  mret_target_q <= clear_lsb(mepc_i);
                  state_q       <= ST_DRAIN;
                  stall_q       <= 1'b1;
                  flush_q       <= 1'b1;
               end else if (irq_take) begin
                  kind_q       <= KIND_IRQ;
                  trap_cause_q <= {1'b1, 26'd0, irq_code};
                  trap_pc_q    <= clear_lsb(irq_pc_i);
                  trap_val_q   <= 32'd0;
                  state_q      <= ST_DRAIN;
                  stall_q      <= 1'b1;
                  flush_q      <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (drain_done_i) begin
                  state_q       <= ST_COMMIT;
                  flush_q       <= 1'b0;
                  trap_commit_q <= (kind_q != KIND_MRET);
                  mret_commit_q <= (kind_q == KIND_MRET);
               end
            end
            ST_COMMIT: begin
               state_q          <= ST_REDIRECT;
               trap_commit_q    <= 1'b0;
               mret_commit_q    <= 1'b0;
               redirect_valid_q <= 1'b1;
               redirect_pc_q    <= target_d;
            end
            ST_REDIRECT: begin
               if (redirect_ready_i) begin
                  state_q          <= ST_IDLE;
                  stall_q          <= 1'b0;
                  redirect_valid_q <= 1'b0;
                  redirect_pc_q    <= RESET_PC;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign stall_o          = stall_q;
   assign flush_o          = flush_q;
   assign trap_commit_o    = trap_commit_q;
   assign mret_commit_o    = mret_commit_q;
   assign trap_pc_o        = trap_pc_q;
   assign trap_cause_o     = trap_cause_q;
   assign trap_val_o       = trap_val_q;
   assign redirect_valid_o = redirect_valid_q;
   assign redirect_pc_o    = redirect_pc_q;
   assign dbg_state_o      = state_q;

endmodule
